key_event_scheduler: RTL



---
 rtl/key_event_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/key_event_scheduler.sv
// Key event scheduler: buffers decoder make/break strobes into a valid/ready
// event FIFO and injects typematic auto-repeat events for the last pressed key.
module key_event_scheduler #(
    parameter int DEPTH        = 8,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [8:0]               last_change,
    input  logic [511:0]             key_down,
    input  logic                     repeat_en,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [8:0]               evt_code,
    output logic                     evt_make,
    output logic                     evt_repeat,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE - 1);
    localparam logic [AW:0] FULL_CNT   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    // Event word layout: {code[8:0], make, repeat}
    function automatic logic [10:0] pack_evt(input logic [8:0] code, input logic make,
                                             input logic rep);
        return {code, make, rep};
    endfunction

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [8:0]  tracked, tracked_nxt;
    logic        rep_emit;
    logic        key_make;
    logic        tracked_down;

    assign key_make     = key_down[last_change];
    assign tracked_down = key_down[tracked];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tracked <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tracked <= tracked_nxt;
        end
    end

    // Decoder events take precedence over the timer; a break of some other key
    // leaves the timer running, so a coincident repeat is still consumed.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tracked_nxt = tracked;
        rep_emit    = 1'b0;
        if (!repeat_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (key_valid && key_make) begin
            tracked_nxt = last_change;
            cnt_nxt     = '0;
            state_nxt   = DELAY;
        end else if (key_valid && (last_change == tracked)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if ((state != IDLE) && !key_valid && !tracked_down) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        rep_emit  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                REPEAT: begin
                    if (cnt == RATE_LAST) begin
                        rep_emit = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                default: begin
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic [10:0]   push_data;
    logic [10:0]   head;

    assign full      = (count == FULL_CNT);
    assign pop       = evt_valid && evt_ready;
    assign push_req  = key_valid || rep_emit;
    assign push      = push_req && (!full || pop);
    assign push_data = key_valid ? pack_evt(last_change, key_make, 1'b0)
                                 : pack_evt(tracked, 1'b1, 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    // Storage is pure data; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head       = mem[rd_ptr];
    assign evt_valid  = (count != '0);
    assign evt_code   = evt_valid ? head[10:2] : 9'd0;
    assign evt_make   = evt_valid ? head[1] : 1'b0;
    assign evt_repeat = evt_valid ? head[0] : 1'b0;
    assign fifo_count = count;

endmodule
